// File: rtl/uart_fifo_core_param_if.sv
// uart_fifo_core_param_if: wrapper-facing bundle of UART control, FIFO and status signals
interface uart_fifo_core_param_if #(parameter int LVL_W = 5);
  logic [15:0] baud_div;
  logic rx, rx_re, tx_we, err_clr;
  logic [7:0] rx_data, tx_data;
  logic rx_empty, rx_full, tx_empty, tx_full, tx, tx_busy;
  logic [LVL_W-1:0] rx_level, tx_level;
  logic parity_err, frame_err, overrun;
  modport slave(
    input baud_div, rx, rx_re, tx_we, tx_data, err_clr,
    output rx_data, rx_empty, rx_full, rx_level, tx_empty, tx_full, tx_level, tx, tx_busy,
    parity_err, frame_err, overrun
  );
  modport master(
    output baud_div, rx, rx_re, tx_we, tx_data, err_clr,
    input rx_data, rx_empty, rx_full, rx_level, tx_empty, tx_full, tx_level, tx, tx_busy,
    parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_fifo_core_param.sv
// uart_fifo_core_param: full-duplex UART with runtime baud divisor, configurable frame and FWFT FIFOs
module uart_fifo_core_param_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LVL_W-1:0] lvl_q;
  logic push, pop;
  assign empty_o = lvl_q == '0;
  assign full_o = lvl_q == LVL_W'(DEPTH);
  assign level_o = lvl_q;
  assign push = we_i && !full_o;
  assign pop = re_i && !empty_o;
  assign rdata_o = empty_o ? 8'd0 : mem_q[rp_q];
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      lvl_q <= lvl_q + LVL_W'(push) - LVL_W'(pop);
    end
  end
endmodule

module uart_fifo_core_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  uart_fifo_core_param_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} st_e;
  localparam logic [7:0] MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BITS - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  logic [15:0] cnt_q, div_q;
  logic tick;
  assign tick = cnt_q == div_q;
  logic [2:0] sync_q;
  logic s, fall;
  assign s = sync_q[1];
  assign fall = !sync_q[1] && sync_q[2];
  st_e rs_q, rs_d, ts_q, ts_d;
  logic [3:0] rc_q, rc_d;
  logic [2:0] ri_q, ri_d, ti_q, ti_d;
  logic [7:0] rsh_q, rsh_d, tsh_q, tsh_d, tx_head;
  logic [4:0] tc_q, tc_d;
  logic rpar_q, rpar_d, tx_q, tx_d, pe_q, fe_q, ov_q;
  logic rx_push, rx_full, tx_empty, tx_pop, set_pe, set_fe, set_ov, pe_bad, t_end, tpar;
  assign pe_bad = PARITY_EN != 0 && rpar_q != ((^rsh_q) ^ 1'(PARITY_ODD));
  always_comb begin
    rs_d = rs_q;
    rc_d = rc_q;
    ri_d = ri_q;
    rsh_d = rsh_q;
    rpar_d = rpar_q;
    rx_push = 1'b0;
    set_pe = 1'b0;
    set_fe = 1'b0;
    set_ov = 1'b0;
    if (rs_q == IDLE) begin
      if (fall) begin
        rs_d = START;
        rc_d = '0;
        ri_d = '0;
        rsh_d = '0;
      end
    end else if (tick) begin
      rc_d = rc_q + 4'd1;
      if (rs_q == START && rc_q == 4'd7) begin
        rc_d = '0;
        rs_d = s ? IDLE : DATA;
      end else if (rs_q != START && rc_q == 4'hF) begin
        case (rs_q)
          DATA: begin
            rsh_d[ri_q] = s;
            ri_d = ri_q + 3'd1;
            if (ri_q == LAST_BIT) rs_d = PARITY_EN != 0 ? PARITY : STOP;
          end
          PARITY: begin
            rpar_d = s;
            rs_d = STOP;
          end
          default: begin
            rs_d = IDLE;
            set_fe = !s;
            set_ov = s && rx_full;
            rx_push = s && !rx_full;
            set_pe = rx_push && pe_bad;
          end
        endcase
      end
    end
  end
  // STOP ending with more data queued chains straight into the next START
  assign t_end = ts_q != IDLE && tick && tc_q == (ts_q == STOP ? STOP_LAST : 5'd15);
  assign tpar = (^(tsh_q & MASK)) ^ 1'(PARITY_ODD);
  always_comb begin
    ts_d = ts_q;
    tc_d = tc_q;
    ti_d = ti_q;
    tsh_d = tsh_q;
    tx_pop = 1'b0;
    if (ts_q != IDLE && tick) tc_d = t_end ? 5'd0 : tc_q + 5'd1;
    if (t_end) begin
      ts_d = ts_q == START ? DATA : ts_q == PARITY ? STOP : ts_q == STOP ? IDLE :
             ti_q == LAST_BIT ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      ti_d = ts_q == DATA ? ti_q + 3'd1 : ti_q;
    end
    if ((ts_q == IDLE || (t_end && ts_q == STOP)) && !tx_empty) begin
      tx_pop = 1'b1;
      tsh_d = tx_head & MASK;
      ts_d = START;
      tc_d = '0;
      ti_d = '0;
    end
    tx_d = ts_d == START ? 1'b0 : ts_d == DATA ? tsh_d[ti_d] : ts_d == PARITY ? tpar : 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      div_q <= '0;
      sync_q <= '1;
      rs_q <= IDLE;
      rc_q <= '0;
      ri_q <= '0;
      rsh_q <= '0;
      rpar_q <= 1'b0;
      ts_q <= IDLE;
      tc_q <= '0;
      ti_q <= '0;
      tsh_q <= '0;
      tx_q <= 1'b1;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;
      div_q <= tick ? bus.baud_div : div_q;
      sync_q <= {sync_q[1:0], bus.rx};
      rs_q <= rs_d;
      rc_q <= rc_d;
      ri_q <= ri_d;
      rsh_q <= rsh_d;
      rpar_q <= rpar_d;
      ts_q <= ts_d;
      tc_q <= tc_d;
      ti_q <= ti_d;
      tsh_q <= tsh_d;
      tx_q <= tx_d;
      pe_q <= set_pe || (pe_q && !bus.err_clr);
      fe_q <= set_fe || (fe_q && !bus.err_clr);
      ov_q <= set_ov || (ov_q && !bus.err_clr);
    end
  end
  uart_fifo_core_param_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rxf (
    .clk(clk), .rst(rst), .we_i(rx_push), .re_i(bus.rx_re), .wdata_i(rsh_q),
    .rdata_o(bus.rx_data), .empty_o(bus.rx_empty), .full_o(rx_full), .level_o(bus.rx_level)
  );
  uart_fifo_core_param_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_txf (
    .clk(clk), .rst(rst), .we_i(bus.tx_we), .re_i(tx_pop), .wdata_i(bus.tx_data),
    .rdata_o(tx_head), .empty_o(tx_empty), .full_o(bus.tx_full), .level_o(bus.tx_level)
  );
  assign bus.rx_full = rx_full;
  assign bus.tx_empty = tx_empty;
  assign bus.tx = tx_q;
  assign bus.tx_busy = ts_q != IDLE;
  assign bus.parity_err = pe_q;
  assign bus.frame_err = fe_q;
  assign bus.overrun = ov_q;
endmodule
